mc_state_sequencer: RTL and testbench
=====================================

MC_STATE_SEQUENCER -- requirements
Module: mc_state_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 SHALL have: run  in  1  advance enable; low holds all state and outputs.
REQ-003 SHALL have: opcode  in  6  instruction[31:26] from IR, valid from ID onward.
REQ-004 SHALL have: funct  in  6  instruction[5:0] from IR, valid from ID onward.
REQ-005 SHALL have: mem_ready  in  1  memory completion, sampled in IF and MEM.
REQ-006 SHALL have: state  out  3  current phase, feeding the control LUT.
REQ-007 SHALL have: ir_we  out  1  IR load strobe.
REQ-008 SHALL have: mem_req  out  1  memory access request.
REQ-009 SHALL have: instr_done  out  1  one-cycle retire pulse.
REQ-010 SHALL have: illegal_op  out  1  one-cycle undecodable-instruction pulse.

Function
REQ-011 Encodings SHALL be IF=0, ID=1, EXEC=2, MEM=3, WB=4; values 5-7 SHALL force IF next cycle.
REQ-012 Paths SHALL be: LW IF-ID-EXEC-MEM-WB; SW IF-ID-EXEC-MEM; J IF-ID; R-type ADD(0x20)/SUB(0x22)/SLT(0x2A) IF-ID-EXEC-WB; JR (0x08) IF-ID-EXEC; JAL IF-ID-EXEC-MEM; BEQ/BNE IF-ID-EXEC-MEM-WB; ADDI/XORI IF-ID-EXEC-WB.
REQ-013 Opcode/funct SHALL be sampled in ID and latched; later phases use the latched route, not live inputs.
REQ-014 In IF, mem_req SHALL be 1; the FSM SHALL stay in IF until mem_ready=1, then assert ir_we for that single cycle and move to ID.
REQ-015 In MEM for LW/SW only, mem_req SHALL be 1 and the FSM SHALL wait for mem_ready=1; JAL/BEQ/BNE MEM SHALL last exactly one cycle.
REQ-016 mem_req SHALL be 0 in ID, EXEC, WB and in MEM for JAL/BEQ/BNE.
REQ-017 instr_done SHALL pulse in the final phase of a route, in the cycle it exits to IF; MEM completion only when mem_ready=1.
REQ-018 An unlisted opcode or R-type funct in ID SHALL pulse illegal_op and instr_done and return to IF next cycle.
REQ-019 run=0 SHALL freeze state and latched route; ir_we, instr_done and illegal_op SHALL be 0; mem_req SHALL hold its value.
REQ-020 mem_ready SHALL be ignored outside IF and LW/SW MEM.
REQ-021 Minimum latency with mem_ready tied 1: J 2, JR 3, R-type/ADDI/XORI/SW/JAL 4, LW/BEQ/BNE 5 cycles.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IF, clear the latched route and set ir_we=0, mem_req=0, instr_done=0, illegal_op=0, regardless of phase.
REQ-023 After deassertion, the first clock edge SHALL evaluate IF, asserting mem_req=1 combinationally in that cycle.

Configuration
REQ-024 Macro MC_STATE_SEQ_PERF_CNT_EN SHALL add outputs cycle_cnt (32, increments every run=1 cycle) and retire_cnt (32, increments on each instr_done), both wrapping at 2^32 and cleared by reset.
REQ-025 Without MC_STATE_SEQ_PERF_CNT_EN those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-026 State encodings, opcode and funct constants and the route enum SHALL live in shared package mc_cpu_pkg, also used by the control LUT.
REQ-027 Opcode/funct-to-route decoding SHALL be a combinational sub-module mc_seq_route; this module holds the FSM, route latch and counters.

Verification
REQ-028 LW (0x23), mem_ready=1: states 0,1,2,3,4,0; ir_we in cycle 1; instr_done in WB only.
REQ-029 SW (0x2B), mem_ready low 3 cycles in MEM: MEM held 4 cycles with mem_req=1; instr_done with mem_ready.
REQ-030 R-type funct 0x08 then opcode 0x3F: JR gives 0,1,2,0; 0x3F gives 0,1,0 with illegal_op=1 in ID.
REQ-031 rst_n low mid-EXEC of BEQ: state=0 immediately, no instr_done; clean refetch after release.
REQ-032 run=0 for 5 cycles in WB of ADDI: state stays 4, no pulses; resumes to IF; with macro, cycle_cnt frozen, retire_cnt +1 on resume.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared CPU constants for the multi-cycle core.
// Contents:
//   state_e  - sequencer phase encodings (also the control LUT index)
//   Op*/Fn*  - instruction opcode (IR[31:26]) and R-type funct (IR[5:0]) values
//   route_e  - per-instruction phase route chosen in ID
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StExec = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSlt   = 6'h2A;

    // RtIllegal is zero so a cleared route latch decodes as "no instruction".
    typedef enum logic [2:0] {
        RtIllegal = 3'd0,
        RtJ       = 3'd1,  // IF-ID
        RtJr      = 3'd2,  // IF-ID-EXEC
        RtAlu     = 3'd3,  // IF-ID-EXEC-WB (R-type ALU, ADDI, XORI)
        RtLw      = 3'd4,  // IF-ID-EXEC-MEM(wait)-WB
        RtSw      = 3'd5,  // IF-ID-EXEC-MEM(wait)
        RtJal     = 3'd6,  // IF-ID-EXEC-MEM(1 cycle)
        RtBranch  = 3'd7   // IF-ID-EXEC-MEM(1 cycle)-WB
    } route_e;

endpackage

// File: rtl/mc_seq_route.sv
// Combinational opcode/funct decoder selecting the phase route of an instruction.
// Ports:
//   opcode - IR[31:26]
//   funct  - IR[5:0], only meaningful for R-type
//   route  - decoded route; RtIllegal for any unlisted opcode or R-type funct
module mc_seq_route
    import mc_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output route_e     route
);

    always_comb begin
        route = RtIllegal;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAdd, FnSub, FnSlt: route = RtAlu;
                    FnJr:                route = RtJr;
                    default:             route = RtIllegal;
                endcase
            end
            OpJ:            route = RtJ;
            OpJal:          route = RtJal;
            OpBeq, OpBne:   route = RtBranch;
            OpAddi, OpXori: route = RtAlu;
            OpLw:           route = RtLw;
            OpSw:           route = RtSw;
            default:        route = RtIllegal;
        endcase
    end

endmodule

// File: rtl/mc_state_sequencer.sv
// Multi-cycle CPU phase sequencer: IF/ID/EXEC/MEM/WB FSM with a route latch.
// Optional build macro: MC_STATE_SEQ_PERF_CNT_EN adds cycle_cnt/retire_cnt counters.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - advance enable; low freezes state, route and counters
//   opcode      - IR[31:26], valid from ID onward
//   funct       - IR[5:0], valid from ID onward
//   mem_ready   - memory completion, only looked at in IF and LW/SW MEM
//   state       - current phase (control LUT index)
//   ir_we       - IR load strobe (IF completion)
//   mem_req     - memory access request
//   instr_done  - one-cycle retire pulse
//   illegal_op  - one-cycle undecodable-instruction pulse
//   cycle_cnt   - (macro only) run=1 cycle count, wraps
//   retire_cnt  - (macro only) instr_done count, wraps
module mc_state_sequencer
    import mc_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        ir_we,
    output logic        mem_req,
    output logic        instr_done,
    output logic        illegal_op
`ifdef MC_STATE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
`endif
);

    state_e state_q, state_d;
    route_e route_q, route_d;
    route_e dec_route;

    logic ir_we_c, mem_req_c, done_c, illegal_c;

    mc_seq_route u_route (
        .opcode (opcode),
        .funct  (funct),
        .route  (dec_route)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIf;
            route_q <= RtIllegal;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        ir_we_c   = 1'b0;
        mem_req_c = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;

        case (state_q)
            StIf: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = StId;
                end
            end
            StId: begin
                // Later phases follow the latched route, never the live IR fields.
                route_d = dec_route;
                case (dec_route)
                    RtIllegal: begin
                        illegal_c = 1'b1;
                        done_c    = 1'b1;
                        state_d   = StIf;
                    end
                    RtJ: begin
                        done_c  = 1'b1;
                        state_d = StIf;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                case (route_q)
                    RtJr: begin
                        done_c  = 1'b1;
                        state_d = StIf;
                    end
                    RtAlu:                        state_d = StWb;
                    RtLw, RtSw, RtJal, RtBranch:  state_d = StMem;
                    default:                      state_d = StIf;
                endcase
            end
            StMem: begin
                case (route_q)
                    RtLw: begin
                        mem_req_c = 1'b1;
                        if (mem_ready) state_d = StWb;
                    end
                    RtSw: begin
                        mem_req_c = 1'b1;
                        if (mem_ready) begin
                            done_c  = 1'b1;
                            state_d = StIf;
                        end
                    end
                    RtJal: begin
                        done_c  = 1'b1;
                        state_d = StIf;
                    end
                    RtBranch: state_d = StWb;
                    default:  state_d = StIf;
                endcase
            end
            StWb: begin
                done_c  = 1'b1;
                state_d = StIf;
            end
            default: state_d = StIf;  // encodings 5-7
        endcase

        // mem_req is left alone here: it is a function of the frozen state, so it holds.
        if (!run) begin
            state_d   = state_q;
            route_d   = route_q;
            ir_we_c   = 1'b0;
            done_c    = 1'b0;
            illegal_c = 1'b0;
        end
    end

    // Reset also masks the outputs so IF does not request memory while held in reset.
    assign state      = state_q;
    assign ir_we      = rst_n & ir_we_c;
    assign mem_req    = rst_n & mem_req_c;
    assign instr_done = rst_n & done_c;
    assign illegal_op = rst_n & illegal_c;

`ifdef MC_STATE_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            if (run)        cycle_cnt_q  <= cycle_cnt_q + 32'd1;
            if (instr_done) retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mc_state_sequencer.sv
module tb_mc_state_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic [2:0]  state;
    logic        ir_we;
    logic        mem_req;
    logic        instr_done;
    logic        illegal_op;
`ifdef MC_STATE_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic [31:0] cyc_save;
    logic [31:0] ret_save;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_state_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .state      (state),
        .ir_we      (ir_we),
        .mem_req    (mem_req),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
`ifdef MC_STATE_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks all outputs for the current cycle, then advances one clock.
    task automatic expect_cyc(input string tag, input int st, input bit we, input bit mr,
                              input bit dn, input bit il);
        #1;
        check_val({tag, ".state"}, 32'(state), st);
        check_val({tag, ".ir_we"}, 32'(ir_we), 32'(we));
        check_val({tag, ".mem_req"}, 32'(mem_req), 32'(mr));
        check_val({tag, ".done"}, 32'(instr_done), 32'(dn));
        check_val({tag, ".illegal"}, 32'(illegal_op), 32'(il));
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b0;
        tick();
        tick();
        // Held in reset: IF encoding but all strobes masked.
        check_val("rst.state", 32'(state), 0);
        check_val("rst.mem_req", 32'(mem_req), 0);
        check_val("rst.ir_we", 32'(ir_we), 0);
`ifdef MC_STATE_SEQ_PERF_CNT_EN
        check_val("rst.cycle_cnt", cycle_cnt, 0);
        check_val("rst.retire_cnt", retire_cnt, 0);
`endif
        rst_n = 1'b1;
        #1;
        check_val("rel.mem_req", 32'(mem_req), 1);

        // IF waits for mem_ready; then LW with opcode changed after ID (route latched).
        expect_cyc("ifw0", 0, 0, 1, 0, 0);
        expect_cyc("ifw1", 0, 0, 1, 0, 0);
        mem_ready = 1'b1;
        opcode    = 6'h23;
        expect_cyc("lw_if", 0, 1, 1, 0, 0);
        expect_cyc("lw_id", 1, 0, 0, 0, 0);
        opcode = 6'h02;
        expect_cyc("lw_ex", 2, 0, 0, 0, 0);
        expect_cyc("lw_mem", 3, 0, 1, 0, 0);
        expect_cyc("lw_wb", 4, 0, 0, 1, 0);

        // SW with mem_ready low for three MEM cycles.
        opcode = 6'h2B;
        expect_cyc("sw_if", 0, 1, 1, 0, 0);
        expect_cyc("sw_id", 1, 0, 0, 0, 0);
        expect_cyc("sw_ex", 2, 0, 0, 0, 0);
        mem_ready = 1'b0;
        expect_cyc("sw_mw0", 3, 0, 1, 0, 0);
        expect_cyc("sw_mw1", 3, 0, 1, 0, 0);
        expect_cyc("sw_mw2", 3, 0, 1, 0, 0);
        mem_ready = 1'b1;
        expect_cyc("sw_mem", 3, 0, 1, 1, 0);

        // J: two cycles.
        opcode = 6'h02;
        expect_cyc("j_if", 0, 1, 1, 0, 0);
        expect_cyc("j_id", 1, 0, 0, 1, 0);

        // R-type ADD.
        opcode = 6'h00;
        funct  = 6'h20;
        expect_cyc("add_if", 0, 1, 1, 0, 0);
        expect_cyc("add_id", 1, 0, 0, 0, 0);
        expect_cyc("add_ex", 2, 0, 0, 0, 0);
        expect_cyc("add_wb", 4, 0, 0, 1, 0);

        // JR then illegal opcode 0x3F.
        funct = 6'h08;
        expect_cyc("jr_if", 0, 1, 1, 0, 0);
        expect_cyc("jr_id", 1, 0, 0, 0, 0);
        expect_cyc("jr_ex", 2, 0, 0, 1, 0);
        opcode = 6'h3F;
        expect_cyc("ill_if", 0, 1, 1, 0, 0);
        expect_cyc("ill_id", 1, 0, 0, 1, 1);

        // Unlisted R-type funct.
        opcode = 6'h00;
        funct  = 6'h21;
        expect_cyc("illf_if", 0, 1, 1, 0, 0);
        expect_cyc("illf_id", 1, 0, 0, 1, 1);

        // JAL: MEM is one cycle and ignores mem_ready.
        opcode = 6'h03;
        expect_cyc("jal_if", 0, 1, 1, 0, 0);
        expect_cyc("jal_id", 1, 0, 0, 0, 0);
        expect_cyc("jal_ex", 2, 0, 0, 0, 0);
        mem_ready = 1'b0;
        expect_cyc("jal_mem", 3, 0, 0, 1, 0);

        // BEQ interrupted by reset in EXEC.
        mem_ready = 1'b1;
        opcode    = 6'h04;
        expect_cyc("beq_if", 0, 1, 1, 0, 0);
        expect_cyc("beq_id", 1, 0, 0, 0, 0);
        #1;
        check_val("beq_ex.state", 32'(state), 2);
        rst_n = 1'b0;
        #1;
        check_val("beq_rst.state", 32'(state), 0);
        check_val("beq_rst.done", 32'(instr_done), 0);
        check_val("beq_rst.mem_req", 32'(mem_req), 0);
        tick();
        rst_n = 1'b1;
        // Clean refetch of BEQ; MEM ignores mem_ready=0.
        expect_cyc("beq2_if", 0, 1, 1, 0, 0);
        mem_ready = 1'b0;
        expect_cyc("beq2_id", 1, 0, 0, 0, 0);
        expect_cyc("beq2_ex", 2, 0, 0, 0, 0);
        expect_cyc("beq2_mem", 3, 0, 0, 0, 0);
        expect_cyc("beq2_wb", 4, 0, 0, 1, 0);

        // ADDI frozen for five cycles in WB.
        mem_ready = 1'b1;
        opcode    = 6'h08;
        expect_cyc("addi_if", 0, 1, 1, 0, 0);
        expect_cyc("addi_id", 1, 0, 0, 0, 0);
        expect_cyc("addi_ex", 2, 0, 0, 0, 0);
        run = 1'b0;
`ifdef MC_STATE_SEQ_PERF_CNT_EN
        cyc_save = cycle_cnt;
        ret_save = retire_cnt;
`endif
        for (int i = 0; i < 5; i++) expect_cyc("addi_frz", 4, 0, 0, 0, 0);
`ifdef MC_STATE_SEQ_PERF_CNT_EN
        check_val("frz.cycle_cnt", cycle_cnt, cyc_save);
        check_val("frz.retire_cnt", retire_cnt, ret_save);
`endif
        run = 1'b1;
        expect_cyc("addi_wb", 4, 0, 0, 1, 0);
`ifdef MC_STATE_SEQ_PERF_CNT_EN
        check_val("res.retire_cnt", retire_cnt, ret_save + 32'd1);
        check_val("res.cycle_cnt", cycle_cnt, cyc_save + 32'd1);
`endif
        expect_cyc("end_if", 0, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
